// File: rtl/median_rr_arbiter.sv
// median_rr_arbiter: round-robin sharing of one 3x3 median engine across NREQ pixel requesters
module median_rr_arbiter #(
    parameter int  WIDTH = 8,
    parameter int  NREQ  = 2,
    parameter int  TMO   = 64,
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_di,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      med_di,
    output logic                  med_dsi,
    input  logic [WIDTH-1:0]      med_do,
    input  logic                  med_dso,
    output logic [WIDTH-1:0]      res_do,
    output logic                  res_vld,
    output logic [IW-1:0]         res_id,
    output logic                  busy,
    output logic                  err
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;
    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d, idx_q, idx_d, pick_idx, nxt_ptr;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        wd_q, wd_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  med_di_q, med_di_d, res_do_q, res_do_d;
    logic [IW-1:0]     res_id_q, res_id_d;
    logic              med_dsi_q, med_dsi_d, res_vld_q, res_vld_d, busy_q, busy_d, err_q, err_d;
    logic              pick_vld;
    logic              abort;
    assign nxt_ptr = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
    assign abort   = (wd_q == 8'(TMO - 1));
    assign gnt     = gnt_q;
    assign med_di  = med_di_q;
    assign med_dsi = med_dsi_q;
    assign res_do  = res_do_q;
    assign res_vld = res_vld_q;
    assign res_id  = res_id_q;
    assign busy    = busy_q;
    assign err     = err_q;
    // first asserted request at or above the pointer, wrapping around
    always_comb begin
        int c;
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        for (int j = 0; j < NREQ; j++) begin
            c = int'(ptr_q) + j;
            c = (c >= NREQ) ? c - NREQ : c;
            if (!pick_vld && req[c[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = c[IW-1:0];
            end
        end
    end
    // state and every registered output, cleared asynchronously
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            gnt_q     <= '0;
            med_di_q  <= '0;
            med_dsi_q <= 1'b0;
            res_do_q  <= '0;
            res_vld_q <= 1'b0;
            res_id_q  <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            gnt_q     <= gnt_d;
            med_di_q  <= med_di_d;
            med_dsi_q <= med_dsi_d;
            res_do_q  <= res_do_d;
            res_vld_q <= res_vld_d;
            res_id_q  <= res_id_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end
    // window sequencing: grant, 9-pixel burst, wait for the engine or the watchdog
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = pick_vld ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = (cnt_q == 4'd8) ? S_WAIT : S_LOAD;
            S_WAIT:  state_d = (med_dso || abort) ? S_IDLE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end
    // datapath and output values for the next cycle
    always_comb begin
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        gnt_d     = gnt_q;
        med_di_d  = med_di_q;
        med_dsi_d = (state_q == S_LOAD);
        res_do_d  = res_do_q;
        res_id_d  = res_id_q;
        res_vld_d = 1'b0;
        err_d     = 1'b0;
        busy_d    = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    idx_d = pick_idx;
                    gnt_d = NREQ'(1) << pick_idx;
                    cnt_d = '0;
                end
            end
            S_LOAD: begin
                med_di_d = req_di[int'(idx_q)*WIDTH +: WIDTH];
                cnt_d    = cnt_q + 4'd1;
                gnt_d    = (cnt_q == 4'd8) ? '0 : gnt_q;
                wd_d     = '0;
            end
            S_WAIT: begin
                if (med_dso) begin
                    res_do_d  = med_do;
                    res_id_d  = idx_q;
                    res_vld_d = 1'b1;
                    ptr_d     = nxt_ptr;
                end else if (abort) begin
                    err_d = 1'b1;
                    ptr_d = nxt_ptr;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_median_rr_arbiter.sv
// tb_median_rr_arbiter: scoreboard bench with requester and median-engine models
module tb_median_rr_arbiter;
    localparam int W = 8, N = 2, TMO = 64, IW = $clog2(N);
    logic           CLK = 0, nRST = 0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_di = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   med_di, med_do, res_do;
    logic           med_dsi, med_dso, res_vld, busy, err;
    logic [IW-1:0]  res_id;
    logic           eng_dso = 0, spur_dso = 0, eng_silent = 0;
    logic [W-1:0]   eng_do = '0, spur_do = '0;
    int vectors = 0, miscompares = 0;
    logic [W-1:0] pix [N][9];
    typedef struct packed {int id; logic [W-1:0] med;} exp_t;
    exp_t sb[$];
    exp_t e;
    int gnt_log[$];
    int cur_id = 0;
    logic [N-1:0] gnt_prev = '0;
    int pcnt [N];
    logic [W-1:0] ebuf [9];
    int en = 0, ecd = 0;
    bit armed = 0;

    assign med_dso = eng_dso | spur_dso;
    assign med_do  = spur_dso ? spur_do : eng_do;

    median_rr_arbiter #(.WIDTH(W), .NREQ(N), .TMO(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .req(req), .req_di(req_di), .gnt(gnt),
        .med_di(med_di), .med_dsi(med_dsi), .med_do(med_do), .med_dso(med_dso),
        .res_do(res_do), .res_vld(res_vld), .res_id(res_id), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] med9(input logic [W-1:0] v [9]);
        logic [W-1:0] a [9];
        logic [W-1:0] t;
        a = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[4];
    endfunction

    function automatic logic [W-1:0] exp_med(input int id);
        logic [W-1:0] tmp [9];
        for (int j = 0; j < 9; j++) tmp[j] = pix[id][j];
        return med9(tmp);
    endfunction

    // scoreboard: push on each new grant, pop on result or abort
    always @(negedge CLK) begin
        if (!nRST) begin
            sb.delete();
            gnt_prev = '0;
        end else begin
            if (gnt != '0) begin
                vectors++;
                if (!$onehot(gnt)) begin miscompares++; $display("FAIL gnt_onehot got=%b", gnt); end
            end
            if (gnt_prev == '0 && gnt != '0) begin
                for (int i = 0; i < N; i++) if (gnt[i]) cur_id = i;
                gnt_log.push_back(cur_id);
                sb.push_back('{cur_id, exp_med(cur_id)});
            end
            gnt_prev = gnt;
            if (res_vld) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL res_unexpected got do=%0d id=%0d expected none", res_do, res_id);
                end else begin
                    e = sb.pop_front();
                    if (res_do !== e.med || res_id !== IW'(e.id)) begin
                        miscompares++;
                        $display("FAIL result got do=%0d id=%0d expected do=%0d id=%0d", res_do, res_id, e.med, e.id);
                    end
                end
            end
            if (err && sb.size() != 0) void'(sb.pop_front());
        end
    end

    // requesters present one pixel per granted cycle
    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (!nRST || !gnt[i]) pcnt[i] = 0;
            else if (pcnt[i] < 9) begin
                req_di[i*W +: W] = pix[i][pcnt[i]];
                pcnt[i]++;
            end
        end
    end

    // engine: collect 9 pixels, answer with their median 8 cycles after the last one
    always @(negedge CLK) begin
        eng_dso = 0;
        if (!nRST) begin
            en = 0; armed = 0;
        end else if (med_dsi) begin
            ebuf[en] = med_di;
            en++;
            if (en == 9) begin
                vectors++;
                for (int j = 0; j < 9; j++)
                    if (ebuf[j] !== pix[cur_id][j]) begin
                        miscompares++;
                        $display("FAIL burst id=%0d pixel %0d got=%0d expected=%0d", cur_id, j, ebuf[j], pix[cur_id][j]);
                        break;
                    end
                en = 0; armed = 1; ecd = 8;
            end
        end else if (armed) begin
            ecd--;
            if (ecd == 0) begin
                armed = 0;
                if (!eng_silent) begin eng_dso = 1; eng_do = med9(ebuf); end
            end
        end
    end

    task automatic tick;
        @(negedge CLK); #1;
    endtask

    task automatic wait_grant(output bit ok);
        int n = 0;
        while (gnt == '0 && n < 200) begin tick(); n++; end
        ok = (gnt != '0);
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 300) begin tick(); n++; end
        tick();
    endtask

    task automatic do_reset;
        nRST = 0; tick(); tick();
        gnt_log.delete();
        nRST = 1; tick();
    endtask

    task automatic test_reset;
        nRST = 0; req = '0;
        repeat (3) tick();
        vectors++;
        if ({gnt, med_dsi, res_vld, err, busy} !== '0) begin
            miscompares++; $display("FAIL reset_ctrl got=%b expected=0", {gnt, med_dsi, res_vld, err, busy});
        end
        vectors++;
        if ({med_di, res_do, res_id} !== '0) begin
            miscompares++; $display("FAIL reset_data got=%h expected=0", {med_di, res_do, res_id});
        end
        nRST = 1; tick(); tick();
        vectors++;
        if (busy !== 1'b0 || gnt !== '0) begin
            miscompares++; $display("FAIL idle_no_req got busy=%b gnt=%b expected 0", busy, gnt);
        end
    endtask

    task automatic test_single;
        bit ok; int gc = 0, dc = 0, n = 0;
        req = 2'b01;
        wait_grant(ok);
        req = '0;
        vectors++;
        if (!ok || gnt !== 2'b01) begin miscompares++; $display("FAIL t1_grant got=%b expected=01", gnt); end
        for (int k = 0; k < 12; k++) begin gc += int'(gnt[0]); dc += int'(med_dsi); tick(); end
        vectors++;
        if (gc != 9) begin miscompares++; $display("FAIL t1_gnt_len got=%0d expected=9", gc); end
        vectors++;
        if (dc != 9) begin miscompares++; $display("FAIL t1_dsi_len got=%0d expected=9", dc); end
        while (!res_vld && n < 40) begin tick(); n++; end
        vectors++;
        if (res_vld !== 1'b1 || res_do !== 8'd5 || res_id !== 1'b0) begin
            miscompares++; $display("FAIL t1_result got vld=%b do=%0d id=%0d expected 1/5/0", res_vld, res_do, res_id);
        end
        tick();
        vectors++;
        if (res_vld !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL t1_after got vld=%b busy=%b expected 0/0", res_vld, busy);
        end
    endtask

    task automatic test_round_robin;
        int n = 0;
        do_reset();
        req = 2'b11;
        while (gnt_log.size() < 4 && n < 300) begin tick(); n++; end
        req = '0;
        wait_idle();
        vectors++;
        if (gnt_log.size() != 4) begin miscompares++; $display("FAIL rr_count got=%0d expected=4", gnt_log.size()); end
        for (int k = 0; k < gnt_log.size() && k < 4; k++) begin
            vectors++;
            if (gnt_log[k] != k % 2) begin miscompares++; $display("FAIL rr_order[%0d] got=%0d expected=%0d", k, gnt_log[k], k % 2); end
        end
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL rr_pending got=%0d expected=0", sb.size()); end
    endtask

    task automatic test_back_to_back;
        bit ok; int g, n;
        int exp_ids [4] = '{1, 1, 1, 0};
        gnt_log.delete();
        req = 2'b10;
        wait_grant(ok);
        for (int w = 0; w < 2; w++) begin
            n = 0; while (busy && n < 100) begin tick(); n++; end
            g = 0; while (!busy && g < 5) begin tick(); g++; end
            vectors++;
            if (g != 1) begin miscompares++; $display("FAIL b2b_gap got=%0d expected=1", g); end
            vectors++;
            if (gnt !== 2'b10) begin miscompares++; $display("FAIL b2b_gnt got=%b expected=10", gnt); end
        end
        req = 2'b11;
        n = 0; while (busy && n < 100) begin tick(); n++; end
        wait_grant(ok);
        req = '0;
        vectors++;
        if (gnt !== 2'b01) begin miscompares++; $display("FAIL b2b_wrap got=%b expected=01", gnt); end
        wait_idle();
        vectors++;
        if (gnt_log.size() != 4) begin miscompares++; $display("FAIL b2b_count got=%0d expected=4", gnt_log.size()); end
        for (int k = 0; k < gnt_log.size() && k < 4; k++) begin
            vectors++;
            if (gnt_log[k] != exp_ids[k]) begin miscompares++; $display("FAIL b2b_order[%0d] got=%0d expected=%0d", k, gnt_log[k], exp_ids[k]); end
        end
    endtask

    task automatic test_timeout;
        bit ok, seen_vld = 0; int n = 0;
        eng_silent = 1;
        req = 2'b01;
        wait_grant(ok);
        req = '0;
        while (gnt != '0 && n < 20) begin tick(); n++; end
        n = 0;
        do begin tick(); n++; seen_vld |= res_vld; end while (!err && n < 100);
        vectors++;
        if (err !== 1'b1 || n != 64) begin miscompares++; $display("FAIL tmo_delay got err=%b after %0d expected 1 after 64", err, n); end
        vectors++;
        if (seen_vld) begin miscompares++; $display("FAIL tmo_vld got=1 expected=0"); end
        tick();
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL tmo_after got busy=%b err=%b expected 0/0", busy, err); end
        eng_silent = 0;
        req = 2'b10;
        wait_grant(ok);
        req = '0;
        vectors++;
        if (gnt !== 2'b10) begin miscompares++; $display("FAIL tmo_next got=%b expected=10", gnt); end
        n = 0; while (!res_vld && n < 60) begin tick(); n++; end
        vectors++;
        if (res_vld !== 1'b1 || res_id !== 1'b1) begin miscompares++; $display("FAIL tmo_next_res got vld=%b id=%0d expected 1/1", res_vld, res_id); end
        wait_idle();
    endtask

    task automatic test_async_reset;
        bit ok;
        req = 2'b01;
        wait_grant(ok);
        req = '0;
        wait_idle();
        req = 2'b11;
        wait_grant(ok);
        vectors++;
        if (gnt !== 2'b10) begin miscompares++; $display("FAIL ar_pre got=%b expected=10", gnt); end
        repeat (3) tick();
        #2 nRST = 0;
        #1;
        vectors++;
        if (gnt !== '0 || med_dsi !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL ar_async got gnt=%b dsi=%b busy=%b expected 0", gnt, med_dsi, busy);
        end
        tick(); tick();
        gnt_log.delete();
        nRST = 1;
        wait_grant(ok);
        req = '0;
        vectors++;
        if (gnt !== 2'b01) begin miscompares++; $display("FAIL ar_first got=%b expected=01", gnt); end
        wait_idle();
    endtask

    task automatic test_spurious;
        bit ok; int nv = 0;
        tick();
        spur_do = 8'd77; spur_dso = 1; tick(); spur_dso = 0;
        vectors++;
        if (res_vld !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL sp_idle got vld=%b busy=%b expected 0/0", res_vld, busy); end
        req = 2'b01;
        wait_grant(ok);
        req = '0;
        tick(); tick();
        spur_dso = 1; tick(); spur_dso = 0;
        vectors++;
        if (res_vld !== 1'b0 || gnt !== 2'b01) begin miscompares++; $display("FAIL sp_load got vld=%b gnt=%b expected 0/01", res_vld, gnt); end
        for (int k = 0; k < 40; k++) begin
            if (res_vld) begin
                nv++;
                vectors++;
                if (res_do !== exp_med(0)) begin miscompares++; $display("FAIL sp_value got=%0d expected=%0d", res_do, exp_med(0)); end
            end
            tick();
        end
        vectors++;
        if (nv != 1 || busy !== 1'b0) begin miscompares++; $display("FAIL sp_count got=%0d busy=%b expected 1/0", nv, busy); end
    endtask

    initial begin
        for (int j = 0; j < 9; j++) pix[0][j] = W'(9 - j);
        pix[1] = '{8'd20, 8'd50, 8'd10, 8'd40, 8'd30, 8'd90, 8'd70, 8'd60, 8'd80};
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end
endmodule
